c7blsu_ctl: RTL and testbench
=============================

# c7blsu_ctl

Load/store control unit sitting between the execute stage and the data memory bus. It accepts one memory operation in E and checks alignment in LS1, raising an ALE exception pulse on misalignment. Otherwise it issues a single-beat request on a req/gnt data bus and waits for the response, then completes in LS3 with sign/zero-extended load data or a store-finish pulse. It drives the completion signals the execute control logic uses to end its LSU stall.

## Interface
- `AW`, default 32: address width.
- `RW`, default 5: destination register index width.
- `clk`  in  1  clock; all state changes on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `lsu_vld_e`  in  1  memory op valid in E; single-cycle pulse.
- `lsu_op_e`  in  4  {store, unsigned, size[1:0]}; size 00=byte, 01=half, 10=word, 11 treated as word.
- `lsu_addr_e`  in  AW  byte address.
- `lsu_wdata_e`  in  32  store data, right-aligned.
- `lsu_rd_e`  in  RW  load destination.
- `lsu_except_ale_ls1`  out  1  misalignment pulse.
- `lsu_except_buserr_ls3`  out  1  bus-error completion pulse (see Configuration).
- `lsu_data_valid_ls3`  out  1  load completion pulse.
- `lsu_wr_fin_ls3`  out  1  store completion pulse.
- `lsu_rdata_ls3`  out  32  extended load data; valid with `lsu_data_valid_ls3`.
- `lsu_rd_ls3`  out  RW  destination; valid with `lsu_data_valid_ls3`.
- `lsu_badv_ls`  out  AW  faulting address; valid with either exception pulse.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AW  word-aligned address {addr[AW-1:2],2'b00}.
- `mem_wstrb`  out  4  byte strobes.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  response valid.
- `mem_rdata`  in  32  read word.
- `mem_err`  in  1  response error, qualified by `mem_rvalid`.

## Operation
- FSM states: IDLE, LS1, REQ, RESP, DONE.
- IDLE:
  - `lsu_vld_e` captures op, addr, wdata and rd into registers and moves to LS1.
  - `lsu_vld_e` in any other state is ignored; upstream stall logic guarantees none arrives.
- LS1: alignment check.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Misaligned: pulse `lsu_except_ale_ls1`, load `lsu_badv_ls`, go to IDLE; no bus request is issued.
  - Aligned: assert `mem_req` this cycle. With `mem_gnt` go to RESP, else go to REQ.
- REQ: hold `mem_req`; `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` stay stable until `mem_gnt`, then go to RESP.
- RESP: wait for `mem_rvalid`.
  - Register the data (or error) and go to DONE.
  - `mem_rvalid` in any other state is ignored.
- DONE, one cycle, then IDLE. Exactly one of these pulses:
  - `lsu_data_valid_ls3` for a load;
  - `lsu_wr_fin_ls3` for a store;
  - `lsu_except_buserr_ls3` for an error response.
- Strobes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Write data lanes: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load data:
  - Extract lane with rdata >> (8*addr[1:0]).
  - Byte and half are sign-extended unless the unsigned bit is set. Word is passed through.

## Timing
- Reset values:
  - state = IDLE;
  - `mem_req`, `mem_we` and all pulse outputs = 0;
  - `mem_wstrb`, `mem_addr`, `mem_wdata`, `lsu_rdata_ls3`, `lsu_rd_ls3` and `lsu_badv_ls` = 0.
- `lsu_vld_e` at cycle T:
  - ALE pulses at T+1.
  - `mem_req` rises at T+1.
  - Best case, gnt at T+1 and rvalid at T+2, completion pulse at T+3.
- No completion or exception pulse ever occurs in the same cycle as an accepted `lsu_vld_e`.
- Every pulse is high for exactly one cycle. `mem_req` deasserts the cycle after gnt.
- Reset mid-operation: FSM returns to IDLE the next edge; `mem_req` drops.
  - A later stray `mem_rvalid` is ignored.
  - No completion pulse is produced for the aborted op.

## Configuration
- `C7B_LSU_BUSERR_EN` defined:
  - `mem_rvalid` with `mem_err` completes with `lsu_except_buserr_ls3` and `lsu_badv_ls` = op address.
  - `lsu_data_valid_ls3` and `lsu_wr_fin_ls3` stay low for that op.
- Not defined:
  - `mem_err` is ignored and the op completes normally.
  - `lsu_except_buserr_ls3` is tied to 0.

## Test plan
- Word load at 0x100; gnt at T+1; rvalid at T+2 with rdata 0x8765_4321 -> `lsu_data_valid_ls3` at T+3, `lsu_rdata_ls3`=0x8765_4321, rd echoed.
- Signed byte load at 0x103, rdata 0x80FF_FFFF -> rdata_ls3=0xFFFF_FF80; same op unsigned -> 0x0000_0080.
- Half store at 0x102, wdata 0x1234_ABCD:
  - gnt delayed 3 cycles -> req fields stable throughout, wstrb=4'b1100, wdata=0xABCD_ABCD;
  - `lsu_wr_fin_ls3` one cycle after rvalid.
- Word load at 0x101 -> `lsu_except_ale_ls1` at T+1, badv=0x101, `mem_req` never asserted, FSM back in IDLE at T+2.
- With `C7B_LSU_BUSERR_EN`, load at 0x200 answered with mem_err=1 -> `lsu_except_buserr_ls3`=1, badv=0x200, data_valid=0; without the macro -> data_valid=1.
- resetn low while in REQ -> `mem_req`=0 next edge; rvalid pulse after reset -> no completion pulse.

Source files
------------

// File: rtl/c7blsu_ctl_if.sv
// Single-beat req/gnt data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface c7blsu_ctl_if #(
   parameter int AW = 32
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   logic          mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/c7blsu_ctl.sv
// Load/store control: alignment check, single-beat bus access, LS3 completion.
// Optional macro C7B_LSU_BUSERR_EN turns error responses into a bus-error completion.
//
// state | meaning
// IDLE  | waiting for an op from E
// LS1   | alignment check; first request cycle when aligned
// REQ   | request held until granted
// RESP  | waiting for the read/write response
// DONE  | one-cycle completion pulse
module c7blsu_ctl #(
   parameter int AW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          lsu_vld_e,
   input  logic [3:0]    lsu_op_e,
   input  logic [AW-1:0] lsu_addr_e,
   input  logic [31:0]   lsu_wdata_e,
   input  logic [RW-1:0] lsu_rd_e,
   output logic          lsu_except_ale_ls1,
   output logic          lsu_except_buserr_ls3,
   output logic          lsu_data_valid_ls3,
   output logic          lsu_wr_fin_ls3,
   output logic [31:0]   lsu_rdata_ls3,
   output logic [RW-1:0] lsu_rd_ls3,
   output logic [AW-1:0] lsu_badv_ls,
   c7blsu_ctl_if.master  bus
);
   typedef enum logic [2:0] {IDLE, LS1, REQ, RESP, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    op_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [RW-1:0] rd_q;
   logic [31:0]   rdata_q;
   logic [AW-1:0] badv_q;
   logic          err_q;

   logic          op_store, op_unsigned;
   logic [1:0]    op_size;
   logic          misaligned;
   logic [3:0]    strb;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_rdata;
   logic [31:0]   ext_rdata;
   logic          resp_err;

   assign op_store    = op_q[3];
   assign op_unsigned = op_q[2];
   assign op_size     = op_q[1:0];

   assign misaligned = ((op_size == 2'b01) && addr_q[0]) ||
                       (op_size[1] && (addr_q[1:0] != 2'b00));

`ifdef C7B_LSU_BUSERR_EN
   assign resp_err = bus.mem_err;
`else
   logic unused_mem_err;
   assign unused_mem_err = bus.mem_err;
   assign resp_err       = 1'b0;
`endif

   always_comb begin
      strb       = 4'b1111;
      lane_wdata = wdata_q;
      case (op_size)
         2'b00: begin
            strb       = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            strb       = 4'b0011 << addr_q[1:0];
            lane_wdata = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane_rdata = bus.mem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      ext_rdata = lane_rdata;
      case (op_size)
         2'b00: ext_rdata = {{24{lane_rdata[7] & ~op_unsigned}}, lane_rdata[7:0]};
         2'b01: ext_rdata = {{16{lane_rdata[15] & ~op_unsigned}}, lane_rdata[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
         badv_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && lsu_vld_e) begin
            op_q    <= lsu_op_e;
            addr_q  <= lsu_addr_e;
            wdata_q <= lsu_wdata_e;
            rd_q    <= lsu_rd_e;
         end
         if (state_q == LS1 && misaligned) begin
            badv_q <= addr_q;
         end
         if (state_q == RESP && bus.mem_rvalid) begin
            rdata_q <= ext_rdata;
            err_q   <= resp_err;
            if (resp_err) begin
               badv_q <= addr_q;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (lsu_vld_e) state_d = LS1;
         LS1: begin
            if (misaligned)       state_d = IDLE;
            else if (bus.mem_gnt) state_d = RESP;
            else                  state_d = REQ;
         end
         REQ:  if (bus.mem_gnt)    state_d = RESP;
         RESP: if (bus.mem_rvalid) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus fields come straight from the captured op, so they stay stable through REQ.
   always_comb begin
      lsu_except_ale_ls1    = (state_q == LS1) && misaligned;
      lsu_except_buserr_ls3 = (state_q == DONE) && err_q;
      lsu_data_valid_ls3    = (state_q == DONE) && !err_q && !op_store;
      lsu_wr_fin_ls3        = (state_q == DONE) && !err_q && op_store;
      lsu_rdata_ls3         = rdata_q;
      lsu_rd_ls3            = rd_q;
      lsu_badv_ls           = lsu_except_ale_ls1 ? addr_q : badv_q;
      bus.mem_req           = ((state_q == LS1) && !misaligned) || (state_q == REQ);
      bus.mem_we            = bus.mem_req && op_store;
      bus.mem_addr          = {addr_q[AW-1:2], 2'b00};
      bus.mem_wstrb         = bus.mem_req ? strb : 4'b0000;
      bus.mem_wdata         = wdata_q;
      if (bus.mem_req) begin
         bus.mem_wdata = lane_wdata;
      end
   end
endmodule

// File: tb/tb_c7blsu_ctl.sv
// Randomised self-checking bench for c7blsu_ctl against a behavioural op model.
module tb_c7blsu_ctl;
   logic        clk;
   logic        resetn;
   logic        lsu_vld_e;
   logic [3:0]  lsu_op_e;
   logic [31:0] lsu_addr_e;
   logic [31:0] lsu_wdata_e;
   logic [4:0]  lsu_rd_e;
   logic        lsu_except_ale_ls1;
   logic        lsu_except_buserr_ls3;
   logic        lsu_data_valid_ls3;
   logic        lsu_wr_fin_ls3;
   logic [31:0] lsu_rdata_ls3;
   logic [4:0]  lsu_rd_ls3;
   logic [31:0] lsu_badv_ls;

   int n_chk = 0;
   int n_err = 0;

   c7blsu_ctl_if #(.AW(32)) bus ();

   c7blsu_ctl #(.AW(32), .RW(5)) dut (
      .clk                   (clk),
      .resetn                (resetn),
      .lsu_vld_e             (lsu_vld_e),
      .lsu_op_e              (lsu_op_e),
      .lsu_addr_e            (lsu_addr_e),
      .lsu_wdata_e           (lsu_wdata_e),
      .lsu_rd_e              (lsu_rd_e),
      .lsu_except_ale_ls1    (lsu_except_ale_ls1),
      .lsu_except_buserr_ls3 (lsu_except_buserr_ls3),
      .lsu_data_valid_ls3    (lsu_data_valid_ls3),
      .lsu_wr_fin_ls3        (lsu_wr_fin_ls3),
      .lsu_rdata_ls3         (lsu_rdata_ls3),
      .lsu_rd_ls3            (lsu_rd_ls3),
      .lsu_badv_ls           (lsu_badv_ls),
      .bus                   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] pulses();
      return {lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_data_valid_ls3, lsu_wr_fin_ls3};
   endfunction

   // Entered just after a negedge; returns just after a negedge with the DUT idle.
   task automatic run_op(input bit st, input bit uns, input bit [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input int gd, input int rvd, input logic [31:0] rdat, input bit err);
      bit          mis, berr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, lane, e_rdata;
      int          sh;

      sh   = 8 * int'(a[1:0]);
      mis  = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
      lane = rdat >> sh;
      case (sz)
         2'd0: begin
            e_strb  = 4'(1 << a[1:0]);
            e_wdata = wd[7:0] * 32'h0101_0101;
            e_rdata = lane & 32'hFF;
            if (!uns && lane[7]) e_rdata = e_rdata | 32'hFFFF_FF00;
         end
         2'd1: begin
            e_strb  = 4'(3 << a[1:0]);
            e_wdata = wd[15:0] * 32'h0001_0001;
            e_rdata = lane & 32'hFFFF;
            if (!uns && lane[15]) e_rdata = e_rdata | 32'hFFFF_0000;
         end
         default: begin
            e_strb  = 4'hF;
            e_wdata = wd;
            e_rdata = rdat;
         end
      endcase
`ifdef C7B_LSU_BUSERR_EN
      berr = err;
`else
      berr = 1'b0;
`endif

      lsu_vld_e   = 1'b1;
      lsu_op_e    = {st, uns, sz};
      lsu_addr_e  = a;
      lsu_wdata_e = wd;
      lsu_rd_e    = rd;
      check("pulse_at_accept", 32'(pulses()), 32'h0);
      @(negedge clk);
      lsu_vld_e   = 1'b0;
      lsu_addr_e  = $urandom;
      lsu_wdata_e = $urandom;

      if (mis) begin
         check("ale_pulse", 32'(pulses()), 32'h8);
         check("ale_badv", lsu_badv_ls, a);
         check("ale_no_req", 32'(bus.mem_req), 32'h0);
         @(negedge clk);
         check("ale_after", 32'(pulses()), 32'h0);
         check("ale_after_req", 32'(bus.mem_req), 32'h0);
         return;
      end

      for (int i = 0; i <= gd; i++) begin
         check("req", 32'(bus.mem_req), 32'h1);
         check("req_we", 32'(bus.mem_we), 32'(st));
         check("req_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
         check("req_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
         if (st) check("req_wdata", bus.mem_wdata, e_wdata);
         check("req_pulse", 32'(pulses()), 32'h0);
         bus.mem_gnt = (i == gd);
         @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      check("req_drop", 32'(bus.mem_req), 32'h0);
      for (int j = 0; j < rvd; j++) begin
         check("resp_wait_pulse", 32'(pulses()), 32'h0);
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdat;
      bus.mem_err    = err;
      check("resp_pulse", 32'(pulses()), 32'h0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
      bus.mem_rdata  = $urandom;

      check("done_pulse", 32'(pulses()), {28'h0, 1'b0, berr, !berr && !st, !berr && st});
      if (berr) check("buserr_badv", lsu_badv_ls, a);
      if (!berr && !st) begin
         check("load_data", lsu_rdata_ls3, e_rdata);
         check("load_rd", 32'(lsu_rd_ls3), 32'(rd));
      end
      @(negedge clk);
      check("done_after", 32'(pulses()), 32'h0);
   endtask

   initial begin
      bit st, uns;
      bit [1:0] sz;
      logic [31:0] a;

      resetn         = 1'b0;
      lsu_vld_e      = 1'b0;
      lsu_op_e       = 4'h0;
      lsu_addr_e     = 32'h0;
      lsu_wdata_e    = 32'h0;
      lsu_rd_e       = 5'h0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      bus.mem_err    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pulses", 32'(pulses()), 32'h0);
      check("rst_req", {30'h0, bus.mem_req, bus.mem_we}, 32'h0);
      check("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      check("rst_rdata", lsu_rdata_ls3, 32'h0);
      check("rst_rd", 32'(lsu_rd_ls3), 32'h0);
      check("rst_badv", lsu_badv_ls, 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      run_op(0, 0, 2'd2, 32'h100, 32'h0, 5'd7, 0, 0, 32'h8765_4321, 0);
      run_op(0, 0, 2'd0, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80FF_FFFF, 0);
      run_op(0, 1, 2'd0, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80FF_FFFF, 0);
      run_op(1, 0, 2'd1, 32'h102, 32'h1234_ABCD, 5'd0, 3, 1, 32'h0, 0);
      run_op(0, 0, 2'd2, 32'h101, 32'h0, 5'd9, 0, 0, 32'h0, 0);
      run_op(0, 0, 2'd2, 32'h200, 32'h0, 5'd4, 0, 0, 32'h5555_AAAA, 1);

      // Reset while the request waits for grant, then a stray response.
      lsu_vld_e  = 1'b1;
      lsu_op_e   = 4'b0010;
      lsu_addr_e = 32'h300;
      lsu_rd_e   = 5'd1;
      @(negedge clk);
      lsu_vld_e = 1'b0;
      @(negedge clk);
      check("rst_mid_req_held", 32'(bus.mem_req), 32'h1);
      resetn = 1'b0;
      @(negedge clk);
      check("rst_mid_req_drop", 32'(bus.mem_req), 32'h0);
      resetn         = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("stray_rvalid_pulse", 32'(pulses()), 32'h0);
         check("stray_rvalid_req", 32'(bus.mem_req), 32'h0);
         @(negedge clk);
      end

      for (int n = 0; n < 300; n++) begin
         st  = 1'($urandom);
         uns = 1'($urandom);
         sz  = 2'($urandom);
         a   = $urandom;
         if ($urandom_range(3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz >= 2'd2) a[1:0] = 2'b00;
         end
         run_op(st, uns, sz, a, $urandom, 5'($urandom), $urandom_range(3), $urandom_range(3),
                $urandom, $urandom_range(7) == 0);
         repeat ($urandom_range(2)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
